// File: rtl/ascii_odometer.sv
// ascii_odometer
//   Multi-character ASCII candidate generator for the brute-force search path.
//   Steps an NUM_CHARS-wide word through [CHAR_LO, CHAR_HI] like an odometer:
//   char 0 advances by the latched stride on every accepted candidate, and
//   carries ripple upward with modulo wrap. Carry out of the top char means
//   the search space is exhausted.
//
// Optional feature macro: ASCII_ODOMETER_MATCH_EN
//   When defined, adds a target input and a match output; an accepted
//   candidate equal to target ends the search early with match=1.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   pulse: load seed, latch stride, enter RUN
//   stop       in   pulse: abort to IDLE (wins over start)
//   seed       in   first candidate, char i at bits [8i+7:8i]
//   stride     in   step for char 0 (0 treated as 1), sampled on start
//   ready      in   downstream accepts the offered candidate
//   target     in   (MATCH_EN only) word to search for
//   match      out  (MATCH_EN only) target was accepted
//   candidate  out  current candidate, char 0 least significant
//   valid      out  candidate is offered (RUN)
//   busy       out  high in RUN
//   done       out  high in DONE
//   count      out  accepted candidates since start, saturating
module ascii_odometer #(
  parameter int          NUM_CHARS = 4,
  parameter logic [7:0]  CHAR_LO   = 8'h61,
  parameter logic [7:0]  CHAR_HI   = 8'h7A,
  parameter int          COUNT_W   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic [8*NUM_CHARS-1:0] seed,
  input  logic [2:0]             stride,
  input  logic                   ready,
`ifdef ASCII_ODOMETER_MATCH_EN
  input  logic [8*NUM_CHARS-1:0] target,
  output logic                   match,
`endif
  output logic [8*NUM_CHARS-1:0] candidate,
  output logic                   valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_W-1:0]     count
);

  localparam int W = 8 * NUM_CHARS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [2:0]   stride_q;
  logic [2:0]   stride_eff;
  logic [W-1:0] seed_clamped;
  logic [W-1:0] stepped;
  logic         carry_out;
  logic         accept;
  logic         hit;

  assign accept     = (state == RUN) && ready;
  assign stride_eff = (stride == 3'd0) ? 3'd1 : stride;

`ifdef ASCII_ODOMETER_MATCH_EN
  assign hit = accept && (candidate == target);
`else
  assign hit = 1'b0;
`endif

  // Seed characters outside the configured range would never be produced by
  // the stepper, so they are forced to the bottom of the range on load.
  always_comb begin
    seed_clamped = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if ((seed[8*i +: 8] < CHAR_LO) || (seed[8*i +: 8] > CHAR_HI))
        seed_clamped[8*i +: 8] = CHAR_LO;
      else
        seed_clamped[8*i +: 8] = seed[8*i +: 8];
    end
  end

  // Odometer step. Sums are 9 bits wide so nothing overflows before the
  // range check. Because the range spans at least 8 characters and the
  // stride is at most 7, one wrap is always enough. For chars above 0 the
  // increment is only the carry, so the wrap formula collapses to CHAR_LO.
  always_comb begin
    logic [8:0] sum;
    logic [8:0] wrapped;
    logic       carry;
    stepped = candidate;
    carry   = 1'b0;
    sum     = '0;
    wrapped = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (i == 0)
        sum = {1'b0, candidate[7:0]} + {6'd0, stride_q};
      else
        sum = {1'b0, candidate[8*i +: 8]} + {8'd0, carry};
      wrapped = sum - {1'b0, CHAR_HI} - 9'd1 + {1'b0, CHAR_LO};
      if (sum > {1'b0, CHAR_HI}) begin
        stepped[8*i +: 8] = wrapped[7:0];
        carry             = 1'b1;
      end else begin
        stepped[8*i +: 8] = sum[7:0];
        carry             = 1'b0;
      end
    end
    carry_out = carry;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next state: stop beats start, start beats an accept (the in-flight
  // candidate is simply dropped on a restart).
  always_comb begin
    next_state = state;
    if (stop)
      next_state = IDLE;
    else if (start)
      next_state = RUN;
    else if (accept && (carry_out || hit))
      next_state = DONE;
  end

  // Datapath and registered status outputs. Status flags are derived from
  // next_state so they change on the same edge as the state itself. On the
  // final accept the candidate is left at the last accepted value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      candidate <= {NUM_CHARS{CHAR_LO}};
      count     <= '0;
      stride_q  <= 3'd1;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef ASCII_ODOMETER_MATCH_EN
      match     <= 1'b0;
`endif
    end else begin
      valid <= (next_state == RUN);
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
      if (stop) begin
`ifdef ASCII_ODOMETER_MATCH_EN
        match <= 1'b0;
`endif
      end else if (start) begin
        candidate <= seed_clamped;
        stride_q  <= stride_eff;
        count     <= '0;
`ifdef ASCII_ODOMETER_MATCH_EN
        match     <= 1'b0;
`endif
      end else if (accept) begin
        if (count != {COUNT_W{1'b1}})
          count <= count + {{(COUNT_W-1){1'b0}}, 1'b1};
        if (!carry_out && !hit)
          candidate <= stepped;
`ifdef ASCII_ODOMETER_MATCH_EN
        if (hit)
          match <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ascii_odometer.sv
// tb_ascii_odometer
//   Self-checking bench for ascii_odometer with NUM_CHARS=2 over 'a'..'z'.
//   Accepted candidates are checked against a scoreboard queue filled from
//   an independent offset-based odometer model; final status is checked from
//   a vector table plus hand-written corner sequences.
module tb_ascii_odometer;

  localparam int NC = 2;
  localparam int W  = 8 * NC;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop  = 1'b0;
  logic [W-1:0]  seed  = '0;
  logic [2:0]    stride = 3'd1;
  logic          ready = 1'b0;
  logic [W-1:0]  candidate;
  logic          valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
`ifdef ASCII_ODOMETER_MATCH_EN
  logic [W-1:0]  target = '0;
  logic          match;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] sb_q[$];

  ascii_odometer #(.NUM_CHARS(NC), .CHAR_LO(8'h61), .CHAR_HI(8'h7A), .COUNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .stop(stop),
    .seed(seed),
    .stride(stride),
    .ready(ready),
`ifdef ASCII_ODOMETER_MATCH_EN
    .target(target),
    .match(match),
`endif
    .candidate(candidate),
    .valid(valid),
    .busy(busy),
    .done(done),
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] seed;
    logic [2:0]   stride;
    int           exp_count;
    logic [W-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] clampChar(input logic [7:0] c);
    return ((c < 8'h61) || (c > 8'h7A)) ? 8'h61 : c;
  endfunction

  // Model works on alphabet offsets 0..25; bit 16 flags exhaustion.
  function automatic logic [W:0] modelStep(input logic [W-1:0] word, input int s);
    int off0, off1;
    logic top;
    logic [W-1:0] nw;
    off0 = int'(word[7:0]) - 'h61;
    off1 = int'(word[15:8]) - 'h61;
    top  = 1'b0;
    off0 = off0 + s;
    if (off0 >= 26) begin
      off0 = off0 - 26;
      off1 = off1 + 1;
    end
    if (off1 >= 26) begin
      off1 = 0;
      top  = 1'b1;
    end
    nw[7:0]  = 8'(off0 + 'h61);
    nw[15:8] = 8'(off1 + 'h61);
    return {top, nw};
  endfunction

  task automatic pushSequence(input logic [W-1:0] sd, input logic [2:0] st, input int max_n);
    logic [W-1:0] word;
    logic [W:0]   r;
    int s;
    word = {clampChar(sd[15:8]), clampChar(sd[7:0])};
    s = (st == 3'd0) ? 1 : int'(st);
    for (int n = 0; n < max_n; n++) begin
      sb_q.push_back(word);
      r = modelStep(word, s);
      if (r[W]) break;
      word = r[W-1:0];
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] sd, input logic [2:0] st, input logic rdy);
    seed   = sd;
    stride = st;
    ready  = rdy;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic waitDone(input int limit, output int cycles);
    cycles = -1;
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if (done) begin
        cycles = k;
        break;
      end
    end
    if (cycles < 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL done_timeout: got no done, expected done within %0d cycles", limit);
    end
  endtask

  // Scoreboard monitor: every accepted candidate must match the queue head.
  always @(negedge clock) begin
    if (!reset && valid && ready && !start && !stop) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL sb_unexpected: got %0h, expected no accept", candidate);
      end else begin
        checkOutput("sb_candidate", 64'(candidate), 64'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    int cyc;

    vecs[0] = '{16'h6161, 3'd1, 676, 16'h7a7a};
    vecs[1] = '{16'h7a79, 3'd5, 1,   16'h7a79};
    vecs[2] = '{16'h617a, 3'd0, 651, 16'h7a7a};
    vecs[3] = '{16'h7941, 3'd1, 52,  16'h7a7a};
    vecs[4] = '{16'h7a73, 3'd7, 2,   16'h7a7a};

    // Reset state.
    #12;
    checkOutput("rst_candidate", 64'(candidate), 64'h6161);
    checkOutput("rst_valid", 64'(valid), 0);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_done", 64'(done), 0);
    checkOutput("rst_count", 64'(count), 0);
`ifdef ASCII_ODOMETER_MATCH_EN
    checkOutput("rst_match", 64'(match), 0);
`endif
    reset = 1'b0;
    tick();

    // Table-driven full runs to exhaustion with ready held high.
    for (int v = 0; v < 5; v++) begin
      sb_q.delete();
      pushSequence(vecs[v].seed, vecs[v].stride, 1000);
      applyStimulus(vecs[v].seed, vecs[v].stride, 1'b1);
      waitDone(1000, cyc);
      checkOutput($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].exp_count));
      checkOutput($sformatf("v%0d_done", v), 64'(done), 1);
      checkOutput($sformatf("v%0d_valid", v), 64'(valid), 0);
      checkOutput($sformatf("v%0d_busy", v), 64'(busy), 0);
      checkOutput($sformatf("v%0d_count", v), 64'(count), 64'(vecs[v].exp_count));
      checkOutput($sformatf("v%0d_last", v), 64'(candidate), 64'(vecs[v].exp_last));
      checkOutput($sformatf("v%0d_sb_empty", v), 64'(sb_q.size()), 0);
    end

    // Stop from DONE clears done but keeps candidate and count.
    ready = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    checkOutput("stop_done_clr", 64'(done), 0);
    checkOutput("stop_count_kept", 64'(count), 2);
    checkOutput("stop_cand_kept", 64'(candidate), 16'h7a7a);

    // Stride 3 wrap from "xa": accepts "xa" then "ab"; next offered is "db".
    sb_q.delete();
    sb_q.push_back(16'h6178);
    sb_q.push_back(16'h6261);
    applyStimulus(16'h6178, 3'd3, 1'b1);
    tick();
    tick();
    ready = 1'b0;
    @(negedge clock);
    checkOutput("xa_count", 64'(count), 2);
    checkOutput("xa_next", 64'(candidate), 16'h6264);
    checkOutput("xa_sb_empty", 64'(sb_q.size()), 0);

    // Stall: ready 1,0,0,1 from "aa".
    sb_q.delete();
    sb_q.push_back(16'h6161);
    sb_q.push_back(16'h6162);
    applyStimulus(16'h6161, 3'd1, 1'b1);
    tick();
    ready = 1'b0;
    @(negedge clock);
    checkOutput("stall_hold1", 64'(candidate), 16'h6162);
    tick();
    @(negedge clock);
    checkOutput("stall_hold2", 64'(candidate), 16'h6162);
    checkOutput("stall_valid", 64'(valid), 1);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    @(negedge clock);
    checkOutput("stall_next", 64'(candidate), 16'h6163);
    checkOutput("stall_count", 64'(count), 2);
    checkOutput("stall_sb_empty", 64'(sb_q.size()), 0);

    // Stop in RUN returns to IDLE, keeps candidate and count.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("stop_run_busy", 64'(busy), 0);
    checkOutput("stop_run_valid", 64'(valid), 0);
    checkOutput("stop_run_count", 64'(count), 2);
    checkOutput("stop_run_cand", 64'(candidate), 16'h6163);

    // Start and stop together: stop wins.
    seed  = 16'h6d6d;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("startstop_busy", 64'(busy), 0);
    checkOutput("startstop_cand", 64'(candidate), 16'h6163);

    // Reset mid-RUN after 10 accepts, then resume from "qq".
    sb_q.delete();
    pushSequence(16'h6161, 3'd1, 10);
    applyStimulus(16'h6161, 3'd1, 1'b1);
    repeat (10) tick();
    ready = 1'b0;
    @(negedge clock);
    checkOutput("mid_count", 64'(count), 10);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_candidate", 64'(candidate), 16'h6161);
    checkOutput("arst_valid", 64'(valid), 0);
    checkOutput("arst_busy", 64'(busy), 0);
    checkOutput("arst_count", 64'(count), 0);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("arst_stays_idle", 64'(valid), 0);
    applyStimulus(16'h7171, 3'd1, 1'b0);
    checkOutput("resume_cand", 64'(candidate), 16'h7171);
    checkOutput("resume_count", 64'(count), 0);
    checkOutput("resume_valid", 64'(valid), 1);

    // Restart in RUN with ready high: in-flight candidate is dropped.
    applyStimulus(16'h6d6d, 3'd1, 1'b1);
    ready = 1'b0;
    @(negedge clock);
    checkOutput("restart_cand", 64'(candidate), 16'h6d6d);
    checkOutput("restart_count", 64'(count), 0);
    checkOutput("restart_sb_empty", 64'(sb_q.size()), 0);

`ifdef ASCII_ODOMETER_MATCH_EN
    // Target char0='c', char1='b' is the 29th candidate from "aa".
    target = 16'h6263;
    sb_q.delete();
    pushSequence(16'h6161, 3'd1, 29);
    applyStimulus(16'h6161, 3'd1, 1'b1);
    waitDone(100, cyc);
    checkOutput("m_match", 64'(match), 1);
    checkOutput("m_done", 64'(done), 1);
    checkOutput("m_count", 64'(count), 29);
    checkOutput("m_cand", 64'(candidate), 16'h6263);
    checkOutput("m_sb_empty", 64'(sb_q.size()), 0);
    applyStimulus(16'h6161, 3'd1, 1'b0);
    checkOutput("m_start_clr", 64'(match), 0);
    sb_q.delete();
    pushSequence(16'h6161, 3'd1, 29);
    ready = 1'b1;
    waitDone(100, cyc);
    checkOutput("m_match2", 64'(match), 1);
    ready = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    checkOutput("m_stop_clr", 64'(match), 0);
    target = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
